store_write_buffer: RTL
=======================

Name: store_write_buffer

Overview:
- Posted-write FIFO directly downstream of the single-cycle core's store port (MemWrite, DataAdr, WriteData).
- Absorbs stores in one cycle and drains them in order to a slower data memory over a valid/ready handshake.
- Stalls the core only when full.
- Provides store-to-load forwarding so a load to a still-buffered address returns the youngest buffered data.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, >= 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemWrite  in  1  core store strobe.
- DataAdr  in  AW  core store address.
- WriteData  in  DW  core store data.
- stall  out  1  buffer full; core must hold the current store and PC.
- ld_adr  in  AW  core load address for the forwarding lookup.
- ld_hit  out  1  a buffered entry matches ld_adr.
- ld_data  out  DW  data of the youngest matching entry.
- mem_valid  out  1  head entry presented to memory.
- mem_adr  out  AW  head address.
- mem_wdata  out  DW  head data.
- mem_ready  in  1  memory accepts the head this cycle.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- empty  out  1  count == 0.

Behaviour:
- Reset (reset low, asynchronous):
  - wr_ptr, rd_ptr and count cleared to 0; all entry valid bits cleared.
  - Outputs during and after reset: mem_valid=0, stall=0, ld_hit=0, empty=1, count=0.
  - mem_adr, mem_wdata and ld_data are 0 whenever their qualifier is 0.
- Reset asserted mid-operation: all pending entries are discarded and mem_valid drops immediately (asynchronously); no partial drain.
- Enqueue:
  - On a rising edge with MemWrite=1 and full=0, {DataAdr, WriteData} is written at wr_ptr.
  - wr_ptr advances modulo DEPTH.
- Full:
  - full = (count == DEPTH); stall = full, combinational from registered state only (no path from mem_ready).
  - With MemWrite=1 while full, nothing is written, even if a dequeue happens on the same edge. The core holds, and the store enqueues on the first edge after stall drops.
- Dequeue:
  - mem_valid = !empty.
  - mem_adr and mem_wdata are taken directly from entry rd_ptr. They stay stable while mem_valid=1 and mem_ready=0.
  - On a rising edge with mem_valid=1 and mem_ready=1, the entry is retired and rd_ptr advances modulo DEPTH.
  - mem_ready is ignored when empty.
- Simultaneous enqueue and dequeue (not full, not empty): both pointers advance and count is unchanged.
- Enqueue into an empty buffer at edge N: mem_valid=1 in the cycle after edge N (1-cycle latency). The earliest retirement is edge N+1.
- Ordering: strict FIFO. Memory sees stores in program order, including repeated stores to the same address.
- Forwarding (combinational):
  - Compare word addresses (bits AW-1:2) of all valid entries against ld_adr.
  - ld_hit=1 if any entry matches; ld_data = data of the youngest match, the entry closest behind wr_ptr.
  - An entry retiring this cycle still forwards until the edge.
  - A store being enqueued this cycle does NOT forward until after the edge.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. count disambiguates full from empty.
- No error or overflow state exists; holding the store under stall is the core's obligation.

Test Plan:
- Reset: hold reset=0 for 22 time units with MemWrite=1 -> mem_valid=0, stall=0, count=0, empty=1 throughout; nothing is enqueued.
- Single store:
  - Stimulus: MemWrite=1, DataAdr=100, WriteData=25 for one cycle; mem_ready=1.
  - Response: mem_valid=1 with mem_adr=100, mem_wdata=25 for exactly one cycle, then empty=1.
- Fill and backpressure:
  - Stimulus: mem_ready=0, stores to addresses 96, 100, 104, 108, then a fifth store to 112.
  - Response: count=4 and stall=1; the store to 112 is held and not enqueued.
  - Then raise mem_ready: memory sees 96, 100, 104, 108, 112 in order; stall drops after the first retirement.
- Stable handshake: mem_ready=0 for 5 cycles with the head at 96/7 -> mem_adr and mem_wdata are unchanged every cycle; one retirement occurs when mem_ready=1.
- Forwarding:
  - Stimulus: mem_ready=0; store 100/25, then 100/42, then 104/9; ld_adr=100.
  - Response: ld_hit=1, ld_data=42. With ld_adr=102 (same word): ld_hit=1. With ld_adr=108: ld_hit=0.
- Wrap and mid-operation reset:
  - Run 10 stores with mem_ready toggling every cycle -> all 10 arrive in order; pointers wrap twice.
  - Assert reset with count=3 -> mem_valid=0 immediately and count=0; after release, a new store 100/25 drains correctly.

Source files
------------

// File: rtl/store_write_buffer_if.sv
// Store-port, load-forwarding and memory-side signals of the store write buffer.
// The core/memory side drives through master; the buffer itself connects through slave.
interface store_write_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  logic                         MemWrite;
  logic [AW-1:0]                DataAdr;
  logic [DW-1:0]                WriteData;
  logic                         stall;
  logic [AW-1:0]                ld_adr;
  logic                         ld_hit;
  logic [DW-1:0]                ld_data;
  logic                         mem_valid;
  logic [AW-1:0]                mem_adr;
  logic [DW-1:0]                mem_wdata;
  logic                         mem_ready;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         empty;

  modport master (
    output MemWrite, DataAdr, WriteData, ld_adr, mem_ready,
    input  stall, ld_hit, ld_data, mem_valid, mem_adr, mem_wdata, count, empty
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData, ld_adr, mem_ready,
    output stall, ld_hit, ld_data, mem_valid, mem_adr, mem_wdata, count, empty
  );
endinterface

// File: rtl/store_write_buffer.sv
// Posted-write FIFO between the core store port and data memory, with youngest-match load forwarding.
// Head reaches memory one cycle after enqueue; the core is stalled only while all DEPTH entries are occupied.
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input logic                 clk,
  input logic                 reset,
  store_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    adrMem [DEPTH];
  logic [DW-1:0]    datMem [DEPTH];
  logic [DEPTH-1:0] entryVld;
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    occ;
  logic             full;
  logic             isEmpty;
  logic             doEnq;
  logic             doDeq;
  logic             fwdHit;
  logic [DW-1:0]    fwdDat;
  logic [PW-1:0]    fwdIdx;
  logic             unusedLdLowBits;

  // Fullness comes only from registered occupancy, so stall has no path from mem_ready.
  assign full    = (occ == CW'(DEPTH));
  assign isEmpty = (occ == '0);
  assign doEnq   = bus.MemWrite && !full;
  assign doDeq   = !isEmpty && bus.mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      occ      <= '0;
      entryVld <= '0;
    end else begin
      if (doEnq) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (doDeq) begin
        rdPtr <= rdPtr + PW'(1);
      end
      case ({doEnq, doDeq})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
      // Enqueue and dequeue never target the same slot: that needs full or empty, which blocks one side.
      if (doDeq) begin
        entryVld[rdPtr] <= 1'b0;
      end
      if (doEnq) begin
        entryVld[wrPtr] <= 1'b1;
      end
    end
  end

  // Payload storage is qualified by entryVld/occ, so it needs no reset.
  always_ff @(posedge clk) begin
    if (doEnq) begin
      adrMem[wrPtr] <= bus.DataAdr;
      datMem[wrPtr] <= bus.WriteData;
    end
  end

  // Scan oldest to youngest so the entry closest behind wrPtr wins.
  always_comb begin
    fwdHit = 1'b0;
    fwdDat = '0;
    fwdIdx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      fwdIdx = wrPtr - PW'(1) - PW'(k);
      if (entryVld[fwdIdx] && (adrMem[fwdIdx][AW-1:2] == bus.ld_adr[AW-1:2])) begin
        fwdHit = 1'b1;
        fwdDat = datMem[fwdIdx];
      end
    end
  end

  assign unusedLdLowBits = ^bus.ld_adr[1:0];

  assign bus.stall     = full;
  assign bus.empty     = isEmpty;
  assign bus.count     = occ;
  assign bus.mem_valid = !isEmpty;
  assign bus.mem_adr   = isEmpty ? '0 : adrMem[rdPtr];
  assign bus.mem_wdata = isEmpty ? '0 : datMem[rdPtr];
  assign bus.ld_hit    = fwdHit;
  assign bus.ld_data   = fwdDat;

  headStable: assert property (@(posedge clk) disable iff (!reset)
    (bus.mem_valid && !bus.mem_ready) |=> ($stable(bus.mem_adr) && $stable(bus.mem_wdata)));

  occMatchesValid: assert property (@(posedge clk) disable iff (!reset)
    $countones(entryVld) == int'(occ));
endmodule
